crc_stream_engine: RTL and testbench

- Parametrised, streaming CRC generator/checker. It is the next generation of the team's fixed CRC-16 byte-parallel update logic.
- Accepts one DATA_W-bit beat per cycle under a valid/ready handshake, with frame delimiting (sof/last).
- Supports configurable polynomial, init, input/output reflection and final XOR.
- Presents the finished CRC, plus a residue-match flag for receive-side checking, under an output valid/ready handshake.

---
 rtl/crc_stream_engine.sv | 156 +++++++++++++++
 tb/tb_crc_stream_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised streaming CRC generator/checker.
//
// Each beat of a frame is folded into the CRC in a single cycle. The
// finished CRC is offered on crc_out. crc_match reports whether the raw
// register equals RESIDUE, which is the receive-side check when the frame
// carries its own appended CRC.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   beat present            in_ready   beat accepted this cycle
//   in_data    beat payload (DATA_W)   in_sof     first beat of frame
//   in_last    last beat of frame
//   crc_valid  result held on crc_out/crc_match
//   crc_ready  downstream takes the result
//   crc_out    final CRC (reflected and XORed as parameterised)
//   crc_match  raw register equalled RESIDUE at frame end
//   frame_err  one-cycle pulse: sof seen mid-frame, frame restarted
module crc_stream_engine #(
    parameter int unsigned      CRC_W   = 16,
    parameter int unsigned      DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_last,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_match,
    output logic              frame_err
);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               valid_q, valid_d;
    logic [CRC_W-1:0]   out_q, out_d;
    logic               match_q, match_d;
    logic               ferr_q, ferr_d;

    logic               beat_acc;
    logic [CRC_W-1:0]   crc_start;
    logic [CRC_W-1:0]   crc_upd;

    function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] v_in);
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] r;
        v = v_in;
        r = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            r    = r << 1;
            r[0] = v[0];
            v    = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] v_in);
        logic [CRC_W-1:0] v;
        logic [CRC_W-1:0] r;
        v = v_in;
        r = '0;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            r    = r << 1;
            r[0] = v[0];
            v    = v >> 1;
        end
        return r;
    endfunction

    // Bit-serial LFSR fully unrolled over the beat. With REFIN the beat is
    // reversed first so that the loop always consumes the MSB.
    function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                    input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0]  c;
        logic [DATA_W-1:0] d;
        logic              fb;
        c = crc_in;
        d = REFIN ? rev_data(data) : data;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ d[DATA_W-1];
            c  = (c << 1) ^ (fb ? POLY : '0);
            d  = d << 1;
        end
        return c;
    endfunction

    assign in_ready  = !valid_q || crc_ready;
    assign beat_acc  = in_valid && in_ready;
    // Any beat taken in IDLE opens a frame, sof or not; sof mid-frame restarts.
    assign crc_start = (state_q == S_IDLE || in_sof) ? INIT : crc_q;
    assign crc_upd   = crc_update(crc_start, in_data);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        valid_d = valid_q;
        out_d   = out_q;
        match_d = match_q;
        ferr_d  = 1'b0;

        if (valid_q && crc_ready) begin
            valid_d = 1'b0;
        end

        if (beat_acc) begin
            ferr_d = (state_q == S_ACCUM) && in_sof;
            if (in_last) begin
                // A new result loaded in the handoff cycle overrides the clear.
                state_d = S_IDLE;
                crc_d   = INIT;
                valid_d = 1'b1;
                out_d   = (REFOUT ? rev_crc(crc_upd) : crc_upd) ^ XOROUT;
                match_d = (crc_upd == RESIDUE);
            end else begin
                state_d = S_ACCUM;
                crc_d   = crc_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            crc_q   <= INIT;
            valid_q <= 1'b0;
            out_q   <= '0;
            match_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            match_q <= match_d;
            ferr_q  <= ferr_d;
        end
    end

    assign crc_valid = valid_q;
    assign crc_out   = out_q;
    assign crc_match = match_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: bench for crc_stream_engine.
// Four instances (CCITT-FALSE, XMODEM, ARC, KERMIT) share one input stream.
// Results are compared with known check values and with a whole-message
// reference model.
module tb_crc_stream_engine;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        in_last;
    logic        crc_ready;

    logic        rdy_w   [4];
    logic        valid_w [4];
    logic [15:0] out_w   [4];
    logic        match_w [4];
    logic        ferr_w  [4];

    localparam logic [15:0] M_POLY   [4] = '{16'h1021, 16'h1021, 16'h8005, 16'h1021};
    localparam logic [15:0] M_INIT   [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    localparam bit          M_REFIN  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit          M_REFOUT [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    crc_stream_engine u_false (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_data(in_data), .in_sof(in_sof), .in_last(in_last),
        .crc_valid(valid_w[0]), .crc_ready(crc_ready), .crc_out(out_w[0]),
        .crc_match(match_w[0]), .frame_err(ferr_w[0])
    );

    crc_stream_engine #(.INIT(16'h0000)) u_xmodem (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_data(in_data), .in_sof(in_sof), .in_last(in_last),
        .crc_valid(valid_w[1]), .crc_ready(crc_ready), .crc_out(out_w[1]),
        .crc_match(match_w[1]), .frame_err(ferr_w[1])
    );

    crc_stream_engine #(.POLY(16'h8005), .INIT(16'h0000), .REFIN(1'b1), .REFOUT(1'b1)) u_arc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[2]),
        .in_data(in_data), .in_sof(in_sof), .in_last(in_last),
        .crc_valid(valid_w[2]), .crc_ready(crc_ready), .crc_out(out_w[2]),
        .crc_match(match_w[2]), .frame_err(ferr_w[2])
    );

    crc_stream_engine #(.POLY(16'h1021), .INIT(16'h0000), .REFIN(1'b1), .REFOUT(1'b1)) u_kermit (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[3]),
        .in_data(in_data), .in_sof(in_sof), .in_last(in_last),
        .crc_valid(valid_w[3]), .crc_ready(crc_ready), .crc_out(out_w[3]),
        .crc_match(match_w[3]), .frame_err(ferr_w[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference: the frame is flattened into one bit stream, then divided
    // bit by bit from the start value.
    function automatic logic [15:0] model_raw(input byte unsigned msg[$], input int j);
        bit          bits[$];
        int unsigned r;
        byte unsigned v;
        bit          fb;
        foreach (msg[k]) begin
            v = msg[k];
            for (int b = 0; b < 8; b++) begin
                if (M_REFIN[j]) bits.push_back(bit'((v >> b) & 8'd1));
                else            bits.push_back(bit'((v >> (7 - b)) & 8'd1));
            end
        end
        r = 32'(M_INIT[j]);
        foreach (bits[i]) begin
            fb = bit'((r >> 15) & 32'd1) ^ bits[i];
            r  = ((r << 1) & 32'hFFFF) ^ (fb ? 32'(M_POLY[j]) : 32'd0);
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] model_out(input logic [15:0] raw, input int j);
        logic [15:0] res;
        if (!M_REFOUT[j]) return raw;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            if (raw[b]) res[15 - b] = 1'b1;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until it is accepted; reports stall cycles.
    task automatic drive_beat(input byte unsigned d, input bit sof, input bit last,
                              input bit rnd, output int unsigned stalls);
        bit took;
        took   = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_last  = last;
        while (!took) begin
            @(negedge clk);
            took = rdy_w[0];
            @(posedge clk);
            #1;
            if (!took) begin
                stalls++;
                if (rnd) crc_ready = 1'($urandom_range(0, 1));
                if (stalls > 200) begin
                    n_total++;
                    $display("FAIL beat_timeout: got no acceptance in %0d cycles, required acceptance", stalls);
                    took = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input byte unsigned msg[$], input bit sof_first, input bit rnd,
                              output int unsigned stalls);
        int unsigned s;
        stalls = 0;
        foreach (msg[k]) begin
            if (rnd && $urandom_range(0, 3) == 0) idle(1);
            if (rnd) crc_ready = 1'($urandom_range(0, 1));
            drive_beat(msg[k], sof_first && (k == 0), k == msg.size() - 1, rnd, s);
            stalls += s;
        end
    endtask

    // Called one cycle after the last beat was accepted.
    task automatic check_result(input string tag, input byte unsigned msg[$]);
        logic [15:0] raw;
        for (int j = 0; j < 4; j++) begin
            raw = model_raw(msg, j);
            check($sformatf("%s_valid%0d", tag, j), 32'(valid_w[j]), 32'd1);
            check($sformatf("%s_out%0d", tag, j), 32'(out_w[j]), 32'(model_out(raw, j)));
            check($sformatf("%s_match%0d", tag, j), 32'(match_w[j]), 32'(raw == 16'h0000));
        end
    endtask

    typedef struct {
        string        txt;
        byte unsigned ext[$];
        logic [15:0]  exp_f, exp_x, exp_a, exp_k;
        logic [3:0]   chk;
        logic         exp_match_x;
    } vec_t;

    initial begin
        vec_t         tbl[4];
        byte unsigned m9[$];
        byte unsigned msg[$];
        int unsigned  st;
        string        s9;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_last = 1'b0;
        crc_ready = 1'b1;

        s9 = "123456789";
        for (int i = 0; i < s9.len(); i++) m9.push_back(s9[i]);

        tbl[0].txt = "123456789"; tbl[0].ext = {};
        tbl[0].exp_f = 16'h29B1; tbl[0].exp_x = 16'h31C3; tbl[0].exp_a = 16'hBB3D; tbl[0].exp_k = 16'h2189;
        tbl[0].chk = 4'b1111; tbl[0].exp_match_x = 1'b0;
        tbl[1].txt = "123456789"; tbl[1].ext = {8'h31, 8'hC3};
        tbl[1].exp_f = '0; tbl[1].exp_x = 16'h0000; tbl[1].exp_a = '0; tbl[1].exp_k = '0;
        tbl[1].chk = 4'b0010; tbl[1].exp_match_x = 1'b1;
        tbl[2].txt = ""; tbl[2].ext = {8'h01};
        tbl[2].exp_f = '0; tbl[2].exp_x = 16'h1021; tbl[2].exp_a = '0; tbl[2].exp_k = '0;
        tbl[2].chk = 4'b0010; tbl[2].exp_match_x = 1'b0;
        tbl[3].txt = ""; tbl[3].ext = {8'h00};
        tbl[3].exp_f = '0; tbl[3].exp_x = 16'h0000; tbl[3].exp_a = '0; tbl[3].exp_k = '0;
        tbl[3].chk = 4'b0010; tbl[3].exp_match_x = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rst_valid%0d", j), 32'(valid_w[j]), 32'd0);
            check($sformatf("rst_out%0d", j), 32'(out_w[j]), 32'd0);
            check($sformatf("rst_match%0d", j), 32'(match_w[j]), 32'd0);
            check($sformatf("rst_ferr%0d", j), 32'(ferr_w[j]), 32'd0);
            check($sformatf("rst_ready%0d", j), 32'(rdy_w[j]), 32'd1);
        end
        reset = 1'b1;
        idle(1);

        // Table vectors, back-to-back with crc_ready=1.
        for (int t = 0; t < 4; t++) begin
            msg = {};
            for (int i = 0; i < tbl[t].txt.len(); i++) msg.push_back(tbl[t].txt[i]);
            foreach (tbl[t].ext[i]) msg.push_back(tbl[t].ext[i]);
            send_frame(msg, 1'b1, 1'b0, st);
            check($sformatf("tbl%0d_stalls", t), st, 32'd0);
            if (tbl[t].chk[0]) check($sformatf("tbl%0d_false", t), 32'(out_w[0]), 32'(tbl[t].exp_f));
            if (tbl[t].chk[1]) check($sformatf("tbl%0d_xmodem", t), 32'(out_w[1]), 32'(tbl[t].exp_x));
            if (tbl[t].chk[2]) check($sformatf("tbl%0d_arc", t), 32'(out_w[2]), 32'(tbl[t].exp_a));
            if (tbl[t].chk[3]) check($sformatf("tbl%0d_kermit", t), 32'(out_w[3]), 32'(tbl[t].exp_k));
            check($sformatf("tbl%0d_match_x", t), 32'(match_w[1]), 32'(tbl[t].exp_match_x));
            check_result($sformatf("tbl%0d", t), msg);
        end
        check("match_false_9", 32'(match_w[0]), 32'd0);

        // Back-pressure: result holds, next beat waits, then handoff+accept together.
        idle(2);
        crc_ready = 1'b0;
        send_frame(m9, 1'b1, 1'b0, st);
        check_result("bp", m9);
        in_valid = 1'b1; in_data = 8'h31; in_sof = 1'b1; in_last = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_ready_low", 32'(rdy_w[0]), 32'd0);
            @(posedge clk);
            #1;
            check("bp_hold", 32'({valid_w[0], out_w[0], match_w[0]}), 32'({1'b1, 16'h29B1, 1'b0}));
        end
        crc_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(rdy_w[0]), 32'd1);
        @(posedge clk);
        #1;
        check("bp_handoff_valid", 32'(valid_w[0]), 32'd0);
        in_valid = 1'b0; in_sof = 1'b0;
        for (int k = 1; k < 9; k++) drive_beat(m9[k], 1'b0, k == 8, 1'b0, st);
        check_result("bp_next", m9);
        check("bp_next_false", 32'(out_w[0]), 32'h29B1);

        // Mid-frame sof restarts the frame and pulses frame_err once.
        idle(2);
        for (int k = 0; k < 4; k++) begin
            drive_beat(m9[k], k == 0, 1'b0, 1'b0, st);
            check("mid_ferr_quiet", 32'(ferr_w[0]), 32'd0);
        end
        drive_beat(m9[0], 1'b1, 1'b0, 1'b0, st);
        for (int j = 0; j < 4; j++) check($sformatf("mid_ferr_pulse%0d", j), 32'(ferr_w[j]), 32'd1);
        drive_beat(m9[1], 1'b0, 1'b0, 1'b0, st);
        check("mid_ferr_clear", 32'(ferr_w[0]), 32'd0);
        for (int k = 2; k < 9; k++) drive_beat(m9[k], 1'b0, k == 8, 1'b0, st);
        check_result("mid", m9);
        check("mid_false", 32'(out_w[0]), 32'h29B1);

        // Reset mid-frame, then while a result is pending.
        idle(2);
        for (int k = 0; k < 4; k++) drive_beat(m9[k], k == 0, 1'b0, 1'b0, st);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 32'(valid_w[0]), 32'd0);
        check("rst_mid_out", 32'(out_w[0]), 32'd0);
        reset = 1'b1;
        crc_ready = 1'b0;
        send_frame(m9, 1'b0, 1'b0, st);
        check_result("rst_pend", m9);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pend_valid", 32'(valid_w[0]), 32'd0);
        check("rst_pend_out", 32'(out_w[0]), 32'd0);
        check("rst_pend_match", 32'(match_w[1]), 32'd0);
        reset = 1'b1;
        crc_ready = 1'b1;
        idle(1);
        send_frame(m9, 1'b1, 1'b0, st);
        check("rst_clean_false", 32'(out_w[0]), 32'h29B1);

        // Randomised frames with random gaps, back-pressure and optional sof.
        for (int f = 0; f < 60; f++) begin
            msg = {};
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) msg.push_back(8'($urandom));
            if (f % 7 == 3) begin
                msg.push_back(model_raw(msg, 1) >> 8);
                msg.push_back(model_raw(msg[0:msg.size()-2], 1) & 8'hFF);
            end
            send_frame(msg, $urandom_range(0, 3) != 0, 1'b1, st);
            check_result($sformatf("rnd%0d", f), msg);
        end
        crc_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
